control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore control sequencer for the bus-based datapath.
- Replaces the hand-driven T0..T7 control strobes with one FSM state per clock.
- Fetches via PC/MAR/MDR/IR, decodes IR[31:27] and drives every datapath select/enable for the instruction.
- Sits beside `datapath`; its outputs connect 1:1 to the datapath's control inputs.

Parameters:
ADD_OP, 5'b00011, ALU opcode driven for address/PC arithmetic steps

Ports:
Clock  in  1  system clock, all state changes on rising edge
clear  in  1  asynchronous reset, active-low
IR  in  32  instruction register contents from datapath
CON_FF  in  1  branch condition flip-flop output
Stop  in  1  external halt request
opcode  out  5  ALU operation select
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/enable
HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin  out  1 each  register load enables
HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout  out  1 each  bus drivers
Read, Write, IncPC  out  1 each  memory read/write, PC increment
Run  out  1  1 = executing, 0 = halted/reset

Behaviour:
- clear=0: state=RESET asynchronously; all outputs 0, including Run. First rising edge after release goes to T0; Run=1 in every state except RESET/HALTED.
- Outputs are a pure decode of (state, IR[31:27]). Every strobe not listed for a step is 0. At most one bus driver per step.
- opcode = IR[31:27] in the ALU step of ALU, imm, mul/div, neg/not classes; otherwise ADD_OP.
- Opcode map:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010
  - addi 01011, andi 01100, ori 01101
  - mul 01110, div 01111, neg 10000, not 10001
  - br 10010, jr 10011, jal 10100
  - in 10101, out 10110, mfhi 10111, mflo 11000
  - nop 11001, halt 11010
  - Undefined opcodes execute as nop.
- Fetch, all instructions:
  - T0: PCout MARin IncPC Zin
  - T1: Zlowout PCin Read MDRin
  - T2: MDRout IRin
- Execute steps, by class:
  - ALU reg-reg: T3 Grb Rout Yin; T4 Grc Rout Zin; T5 Zlowout Gra Rin.
  - addi/andi/ori: T3 Grb Rout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
  - ldi: T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
  - ld: T3–T5 as ldi but T5 = Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg/not: T3 Grb Rout Zin; T4 Zlowout Gra Rin.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 Zlowout PCin only if CON_FF=1 (sampled in T6), otherwise no strobes.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCout Grb Rin (link register named in Rb field); T4 Gra Rout PCin.
  - in: T3 Inportout Gra Rin. out: T3 Gra Rout Outportin.
  - mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
  - nop: ends after T2.
  - halt: T3 → HALTED.
- Instruction end: after the last step of a class, next state is T0, or HALTED if Stop=1 at that edge. Stop is ignored mid-instruction.
- HALTED: Run=0, all strobes 0, held until clear asserts.
- clear mid-instruction: aborts immediately; no partial strobe survives the reset edge.
- Latency in clocks: nop 3; jr/in/out/mfhi/mflo 4; neg/not/jal 5; ALU/imm/ldi 6; mul/div/br 7; ld/st 8.

Test Plan:
- Reset with clear=0 for 2 clocks, release → all outputs 0 during reset; Run=1 and PCout=MARin=IncPC=Zin=1 on first cycle after release.
- IR=0x59080002 (addi r2,r1,2) → T3 Grb/Rout/Yin; T4 Cout/Zin with opcode=01011; T5 Zlowout/Gra/Rin; T0 seen again 6 clocks after prior T0.
- ld: IR=0x00880004 → exact 8-step strobe sequence, Read=1 in T1 and T6 only, Write never 1.
- br: IR=0x9080000C with CON_FF=0 → no PCin after T1; repeat with CON_FF=1 → Zlowout+PCin in T6 only.
- Stop=1 asserted during T4 of an add → add completes T5, then state=HALTED, Run=0, no further T0; pulse clear → fetch resumes.
- halt opcode (0xD0000000) → Run drops after T3; clear asserted mid-ld (T5) → outputs 0 within the same cycle, restart at T0.

Source files
------------

// File: rtl/control_unit_if.sv
// Connection bundle between the control sequencer and the bus-based datapath:
// instruction/condition/stop inputs plus every control strobe and the ALU opcode.
interface control_unit_if;
   // There is no valid/ready handshake on this bundle. The sequencer is a Moore
   // machine, so every output holds for the whole clock cycle of its step. The
   // inputs IR, CON_FF and Stop are sampled as levels on the rising edge.
   logic [31:0] IR;
   logic        CON_FF;
   logic        Stop;

   logic [4:0]  opcode;
   logic        Gra, Grb, Grc, Rin, Rout, BAout;
   logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin;
   logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout;
   logic        Read, Write, IncPC;
   logic        Run;
   logic [3:0]  dbg_state;

   modport master (
      input  IR, CON_FF, Stop,
      output opcode,
      output Gra, Grb, Grc, Rin, Rout, BAout,
      output HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin,
      output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout,
      output Read, Write, IncPC, Run, dbg_state
   );

   modport slave (
      output IR, CON_FF, Stop,
      input  opcode,
      input  Gra, Grb, Grc, Rin, Rout, BAout,
      input  HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin,
      input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout,
      input  Read, Write, IncPC, Run, dbg_state
   );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: one state per T-step, fetch in T0..T2,
// then an execute sequence selected by the instruction class in IR[31:27].
module control_unit #(
   parameter logic [4:0] ADD_OP = 5'b00011
) (
   input logic            Clock,
   input logic            clear,
   control_unit_if.master bus
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
   } state_t;

   typedef enum logic [3:0] {
      C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_BR,
      C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } iclass_t;

   state_t     r_state;
   state_t     w_next_state;
   state_t     w_last_step;
   iclass_t    w_class;
   logic [4:0] w_op;
   logic       w_unused_ir;

   assign w_op          = bus.IR[31:27];
   assign w_unused_ir   = ^bus.IR[26:0];
   assign bus.dbg_state = r_state;

   always_comb begin
      w_class = C_NOP;
      case (w_op)
         5'b00000: w_class = C_LD;
         5'b00001: w_class = C_LDI;
         5'b00010: w_class = C_ST;
         5'b00011, 5'b00100, 5'b00101, 5'b00110,
         5'b00111, 5'b01000, 5'b01001, 5'b01010: w_class = C_ALU;
         5'b01011, 5'b01100, 5'b01101: w_class = C_IMM;
         5'b01110, 5'b01111: w_class = C_MULDIV;
         5'b10000, 5'b10001: w_class = C_NEGNOT;
         5'b10010: w_class = C_BR;
         5'b10011: w_class = C_JR;
         5'b10100: w_class = C_JAL;
         5'b10101: w_class = C_IN;
         5'b10110: w_class = C_OUT;
         5'b10111: w_class = C_MFHI;
         5'b11000: w_class = C_MFLO;
         5'b11010: w_class = C_HALT;
         default:  w_class = C_NOP;  // nop and every undefined opcode
      endcase
   end

   always_comb begin
      w_last_step = S_T7;
      case (w_class)
         C_NOP:                                   w_last_step = S_T2;
         C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT: w_last_step = S_T3;
         C_NEGNOT, C_JAL:                         w_last_step = S_T4;
         C_ALU, C_IMM, C_LDI:                     w_last_step = S_T5;
         C_MULDIV, C_BR:                          w_last_step = S_T6;
         default:                                 w_last_step = S_T7;
      endcase
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) r_state <= S_RESET;
      else        r_state <= w_next_state;
   end

   // Stop only matters on the edge that leaves the last step of an instruction.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_RESET:  w_next_state = S_T0;
         S_HALTED: w_next_state = S_HALTED;
         default: begin
            if (r_state == w_last_step)
               w_next_state = (bus.Stop || w_class == C_HALT) ? S_HALTED : S_T0;
            else
               w_next_state = state_t'(r_state + 4'd1);
         end
      endcase
   end

   always_comb begin
      bus.opcode    = 5'b00000;
      bus.Gra       = 1'b0;
      bus.Grb       = 1'b0;
      bus.Grc       = 1'b0;
      bus.Rin       = 1'b0;
      bus.Rout      = 1'b0;
      bus.BAout     = 1'b0;
      bus.HIin      = 1'b0;
      bus.LOin      = 1'b0;
      bus.Yin       = 1'b0;
      bus.Zin       = 1'b0;
      bus.PCin      = 1'b0;
      bus.IRin      = 1'b0;
      bus.MARin     = 1'b0;
      bus.MDRin     = 1'b0;
      bus.Outportin = 1'b0;
      bus.CONin     = 1'b0;
      bus.HIout     = 1'b0;
      bus.LOout     = 1'b0;
      bus.Zhighout  = 1'b0;
      bus.Zlowout   = 1'b0;
      bus.PCout     = 1'b0;
      bus.MDRout    = 1'b0;
      bus.Inportout = 1'b0;
      bus.Cout      = 1'b0;
      bus.Read      = 1'b0;
      bus.Write     = 1'b0;
      bus.IncPC     = 1'b0;
      bus.Run       = 1'b0;
      if (r_state != S_RESET && r_state != S_HALTED) begin
         bus.Run    = 1'b1;
         bus.opcode = ADD_OP;
      end
      case (r_state)
         S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
         S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
         S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
         S_T3: begin
            case (w_class)
               C_ALU, C_IMM:      begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
               C_LDI, C_LD, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
               C_MULDIV:          begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
               C_NEGNOT: begin
                  bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = w_op;
               end
               C_BR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
               C_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
               C_JAL:  begin bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1; end
               C_IN:   begin bus.Inportout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               C_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Outportin = 1'b1; end
               C_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               C_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (w_class)
               C_ALU:    begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = w_op; end
               C_IMM:    begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = w_op; end
               C_LDI, C_LD, C_ST: begin bus.Cout = 1'b1; bus.Zin = 1'b1; end
               C_MULDIV: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = w_op; end
               C_NEGNOT: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               C_BR:     begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
               C_JAL:    begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            case (w_class)
               C_ALU, C_IMM, C_LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               C_LD, C_ST:          begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
               C_MULDIV:            begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
               C_BR:                begin bus.Cout = 1'b1; bus.Zin = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            case (w_class)
               C_LD:     begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
               C_ST:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
               C_MULDIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
               C_BR: begin
                  if (bus.CON_FF) begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; end
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (w_class)
               C_LD:    begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               C_ST:    bus.Write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a reference model expands each instruction into its
// expected per-cycle output words; a monitor compares one word per clock.
module tb_control_unit;

   localparam logic [4:0] ADD_OP = 5'b00011;

   localparam logic [27:0] M_GRA   = 28'h1 << 0,  M_GRB   = 28'h1 << 1,  M_GRC   = 28'h1 << 2;
   localparam logic [27:0] M_RIN   = 28'h1 << 3,  M_ROUT  = 28'h1 << 4,  M_BAOUT = 28'h1 << 5;
   localparam logic [27:0] M_HIIN  = 28'h1 << 6,  M_LOIN  = 28'h1 << 7,  M_YIN   = 28'h1 << 8;
   localparam logic [27:0] M_ZIN   = 28'h1 << 9,  M_PCIN  = 28'h1 << 10, M_IRIN  = 28'h1 << 11;
   localparam logic [27:0] M_MARIN = 28'h1 << 12, M_MDRIN = 28'h1 << 13, M_OPIN  = 28'h1 << 14;
   localparam logic [27:0] M_CONIN = 28'h1 << 15, M_HIOUT = 28'h1 << 16, M_LOOUT = 28'h1 << 17;
   localparam logic [27:0] M_ZHI   = 28'h1 << 18, M_ZLO   = 28'h1 << 19, M_PCOUT = 28'h1 << 20;
   localparam logic [27:0] M_MDROUT= 28'h1 << 21, M_INPOUT= 28'h1 << 22, M_COUT  = 28'h1 << 23;
   localparam logic [27:0] M_READ  = 28'h1 << 24, M_WRITE = 28'h1 << 25, M_INCPC = 28'h1 << 26;
   localparam logic [27:0] M_RUN   = 28'h1 << 27;

   logic clk;
   logic clear;
   control_unit_if cu_if ();

   control_unit #(.ADD_OP(ADD_OP)) dut (
      .Clock (clk),
      .clear (clear),
      .bus   (cu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [32:0] act;
   assign act = {cu_if.opcode, cu_if.Run, cu_if.IncPC, cu_if.Write, cu_if.Read, cu_if.Cout,
                 cu_if.Inportout, cu_if.MDRout, cu_if.PCout, cu_if.Zlowout, cu_if.Zhighout,
                 cu_if.LOout, cu_if.HIout, cu_if.CONin, cu_if.Outportin, cu_if.MDRin,
                 cu_if.MARin, cu_if.IRin, cu_if.PCin, cu_if.Zin, cu_if.Yin, cu_if.LOin,
                 cu_if.HIin, cu_if.BAout, cu_if.Rout, cu_if.Rin, cu_if.Grc, cu_if.Grb, cu_if.Gra};

   logic [32:0] exp_q[$];
   logic [32:0] model_q[$];
   int checks = 0;
   int fails  = 0;

   // Reference model: strobe list per step, straight from the instruction tables.
   task automatic model_instr(input logic [31:0] ir, input logic con);
      logic [4:0]  op;
      logic [27:0] st[$];
      int          alu;
      op  = ir[31:27];
      alu = -1;
      st.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
      st.push_back(M_ZLO | M_PCIN | M_READ | M_MDRIN);
      st.push_back(M_MDROUT | M_IRIN);
      if (op inside {[5'd3:5'd10]}) begin
         st.push_back(M_GRB | M_ROUT | M_YIN);
         st.push_back(M_GRC | M_ROUT | M_ZIN);
         st.push_back(M_ZLO | M_GRA | M_RIN);
         alu = 4;
      end else if (op inside {[5'd11:5'd13]}) begin
         st.push_back(M_GRB | M_ROUT | M_YIN);
         st.push_back(M_COUT | M_ZIN);
         st.push_back(M_ZLO | M_GRA | M_RIN);
         alu = 4;
      end else if (op == 5'd1) begin
         st.push_back(M_GRB | M_BAOUT | M_YIN);
         st.push_back(M_COUT | M_ZIN);
         st.push_back(M_ZLO | M_GRA | M_RIN);
      end else if (op == 5'd0 || op == 5'd2) begin
         st.push_back(M_GRB | M_BAOUT | M_YIN);
         st.push_back(M_COUT | M_ZIN);
         st.push_back(M_ZLO | M_MARIN);
         if (op == 5'd0) begin
            st.push_back(M_READ | M_MDRIN);
            st.push_back(M_MDROUT | M_GRA | M_RIN);
         end else begin
            st.push_back(M_GRA | M_ROUT | M_MDRIN);
            st.push_back(M_WRITE);
         end
      end else if (op == 5'd14 || op == 5'd15) begin
         st.push_back(M_GRA | M_ROUT | M_YIN);
         st.push_back(M_GRB | M_ROUT | M_ZIN);
         st.push_back(M_ZLO | M_LOIN);
         st.push_back(M_ZHI | M_HIIN);
         alu = 4;
      end else if (op == 5'd16 || op == 5'd17) begin
         st.push_back(M_GRB | M_ROUT | M_ZIN);
         st.push_back(M_ZLO | M_GRA | M_RIN);
         alu = 3;
      end else if (op == 5'd18) begin
         st.push_back(M_GRA | M_ROUT | M_CONIN);
         st.push_back(M_PCOUT | M_YIN);
         st.push_back(M_COUT | M_ZIN);
         st.push_back(con ? (M_ZLO | M_PCIN) : 28'h0);
      end else if (op == 5'd19) st.push_back(M_GRA | M_ROUT | M_PCIN);
      else if (op == 5'd20) begin
         st.push_back(M_PCOUT | M_GRB | M_RIN);
         st.push_back(M_GRA | M_ROUT | M_PCIN);
      end
      else if (op == 5'd21) st.push_back(M_INPOUT | M_GRA | M_RIN);
      else if (op == 5'd22) st.push_back(M_GRA | M_ROUT | M_OPIN);
      else if (op == 5'd23) st.push_back(M_HIOUT | M_GRA | M_RIN);
      else if (op == 5'd24) st.push_back(M_LOOUT | M_GRA | M_RIN);
      else if (op == 5'd26) st.push_back(28'h0);
      for (int i = 0; i < st.size(); i++)
         model_q.push_back({(i == alu) ? op : ADD_OP, M_RUN | st[i]});
   endtask

   // Stop is raised at step stop_step; only the first max_steps words are expected.
   task automatic run_instr(input logic [31:0] ir, input logic con,
                            input int stop_step, input int max_steps);
      int n;
      model_q.delete();
      model_instr(ir, con);
      n = model_q.size();
      if (max_steps < n) n = max_steps;
      for (int i = 0; i < n; i++) exp_q.push_back(model_q[i]);
      cu_if.IR     = ir;
      cu_if.CON_FF = con;
      for (int i = 0; i < n; i++) begin
         if (i == stop_step) cu_if.Stop = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic expect_idle(input int k);
      for (int i = 0; i < k; i++) exp_q.push_back(33'h0);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear      = 1'b0;
      cu_if.Stop = 1'b0;
      for (int i = 0; i < 3; i++) exp_q.push_back(33'h0);
      repeat (2) @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      logic [32:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act !== e) begin
            fails++;
            $display("FAIL step_word: got %h expected %h (dbg_state %0d, IR %h)",
                     act, e, cu_if.dbg_state, cu_if.IR);
         end
      end
   end

   initial begin
      logic [31:0] rnd;
      logic [4:0]  op;
      clear        = 1'b0;
      cu_if.IR     = 32'h0;
      cu_if.CON_FF = 1'b0;
      cu_if.Stop   = 1'b0;
      @(posedge clk); #1;
      do_reset();

      run_instr(32'h59080002, 1'b0, -1, 99);
      run_instr(32'h00880004, 1'b0, -1, 99);
      run_instr(32'h9080000C, 1'b0, -1, 99);
      run_instr(32'h9080000C, 1'b1, -1, 99);
      run_instr(32'h10880004, 1'b0, -1, 99);

      for (int k = 0; k < 150; k++) begin
         rnd = $urandom();
         op  = 5'($urandom_range(0, 31));
         if (op == 5'd26) op = 5'd25;
         rnd[31:27] = op;
         run_instr(rnd, 1'($urandom_range(0, 1)), -1, 99);
      end

      run_instr(32'h18C40000, 1'b0, 4, 99);
      expect_idle(3);
      do_reset();
      run_instr(32'hC8000000, 1'b0, -1, 99);
      run_instr(32'h21080000, 1'b0, -1, 99);

      run_instr(32'hD0000000, 1'b0, -1, 99);
      expect_idle(3);
      do_reset();

      run_instr(32'h00880004, 1'b0, -1, 5);
      clear = 1'b0;
      #1;
      checks++;
      if (act !== 33'h0) begin
         fails++;
         $display("FAIL clear_abort: got %h expected %h", act, 33'h0);
      end
      do_reset();
      run_instr(32'h59080002, 1'b0, -1, 99);

      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
